button_input_conditioner: RTL and testbench

- Conditions the Simon player inputs before the CPU reads them at memory-mapped address 1000.
- Takes two raw 4-bit sources: the on-board BTN and the external JD header. One source is selected, synchronised and debounced per channel.
- Sets sticky per-button press flags. The CPU read strobe clears them, so a short press between polls is never lost.
- Runs on the 50 MHz CPU clock. Sits directly upstream of the CPU data-in mux.

---
 rtl/button_input_conditioner_if.sv | 23 ++
 rtl/button_input_conditioner.sv | 144 ++++++++++++++
 tb/tb_button_input_conditioner.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/button_input_conditioner_if.sv
// Player-input bus between the button conditioner and the CPU input port.
interface button_input_conditioner_if #(
    parameter int WIDTH = 4
);
    logic             src_sel;
    logic [WIDTH-1:0] btn_a;
    logic [WIDTH-1:0] btn_b;
    logic             rd_strobe;
    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] pressed;
    logic             any_pressed;
    logic [7:0]       press_count;

    modport master (
        output src_sel, btn_a, btn_b, rd_strobe,
        input  level, pressed, any_pressed, press_count
    );

    modport slave (
        input  src_sel, btn_a, btn_b, rd_strobe,
        output level, pressed, any_pressed, press_count
    );
endinterface

// File: rtl/button_input_conditioner.sv
// Source mux, 2-flop sync and per-channel debounce with sticky press flags cleared by CPU read.
// Level/press latency DEBOUNCE_CYCLES+2 from raw edge; no backpressure, reads are single-cycle.
module button_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int WIDTH           = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    button_input_conditioner_if.slave     bus
);
    localparam int             CW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES);

    localparam logic [1:0] ST_LOW       = 2'd0;
    localparam logic [1:0] ST_WAIT_HIGH = 2'd1;
    localparam logic [1:0] ST_HIGH      = 2'd2;
    localparam logic [1:0] ST_WAIT_LOW  = 2'd3;

    logic [WIDTH-1:0] raw, sync1, sync2;
    logic             sel_q, sel_prev, blind_hold;
    logic [1:0]       sel_vld;
    logic             sel_switch, blind;

    logic [1:0]       state     [WIDTH];
    logic [1:0]       state_nxt [WIDTH];
    logic [CW-1:0]    cnt       [WIDTH];
    logic [CW-1:0]    cnt_nxt   [WIDTH];
    logic [CW-1:0]    cnt_inc;
    logic [WIDTH-1:0] level_q, level_nxt, ev;
    logic [WIDTH-1:0] pressed_q, pressed_nxt;
    logic             any_q;
    logic [7:0]       count_q, ev_cnt;

    assign raw = bus.src_sel ? bus.btn_a : bus.btn_b;

    // sel_vld keeps the first register fill after reset from looking like a source flip
    assign sel_switch = sel_vld[1] && (sel_q != sel_prev);
    assign blind      = sel_switch || blind_hold;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1      <= '0;
            sync2      <= '0;
            sel_q      <= 1'b0;
            sel_prev   <= 1'b0;
            sel_vld    <= 2'b00;
            blind_hold <= 1'b0;
        end else begin
            sync1      <= raw;
            sync2      <= sync1;
            sel_q      <= bus.src_sel;
            sel_prev   <= sel_q;
            sel_vld    <= {sel_vld[0], 1'b1};
            blind_hold <= sel_switch;
        end
    end

    always_comb begin
        ev     = '0;
        ev_cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            state_nxt[i] = state[i];
            cnt_nxt[i]   = cnt[i];
            level_nxt[i] = level_q[i];
            cnt_inc      = (cnt[i] == CNT_MAX) ? cnt[i] : cnt[i] + CW'(1);
            if (blind) begin
                // park in the stable state matching the held level until the syncs refill
                state_nxt[i] = level_q[i] ? ST_HIGH : ST_LOW;
                cnt_nxt[i]   = '0;
            end else begin
                case (state[i])
                    ST_LOW: begin
                        if (sync2[i]) begin
                            state_nxt[i] = ST_WAIT_HIGH;
                            cnt_nxt[i]   = CW'(1);
                        end
                    end
                    ST_WAIT_HIGH: begin
                        if (!sync2[i]) begin
                            state_nxt[i] = ST_LOW;
                            cnt_nxt[i]   = '0;
                        end else if (cnt_inc == CNT_MAX) begin
                            state_nxt[i] = ST_HIGH;
                            cnt_nxt[i]   = '0;
                            level_nxt[i] = 1'b1;
                            ev[i]        = 1'b1;
                        end else begin
                            cnt_nxt[i]   = cnt_inc;
                        end
                    end
                    ST_HIGH: begin
                        if (!sync2[i]) begin
                            state_nxt[i] = ST_WAIT_LOW;
                            cnt_nxt[i]   = CW'(1);
                        end
                    end
                    default: begin
                        if (sync2[i]) begin
                            state_nxt[i] = ST_HIGH;
                            cnt_nxt[i]   = '0;
                        end else if (cnt_inc == CNT_MAX) begin
                            state_nxt[i] = ST_LOW;
                            cnt_nxt[i]   = '0;
                            level_nxt[i] = 1'b0;
                        end else begin
                            cnt_nxt[i]   = cnt_inc;
                        end
                    end
                endcase
            end
            ev_cnt = ev_cnt + 8'(ev[i]);
        end
    end

    // a press landing on the read edge survives the clear
    assign pressed_nxt = (bus.rd_strobe ? '0 : pressed_q) | ev;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < WIDTH; i++) begin
                state[i] <= ST_LOW;
                cnt[i]   <= '0;
            end
            level_q   <= '0;
            pressed_q <= '0;
            any_q     <= 1'b0;
            count_q   <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                state[i] <= state_nxt[i];
                cnt[i]   <= cnt_nxt[i];
            end
            level_q   <= level_nxt;
            pressed_q <= pressed_nxt;
            any_q     <= |pressed_nxt;
            count_q   <= count_q + ev_cnt;
        end
    end

    assign bus.level       = level_q;
    assign bus.pressed     = pressed_q;
    assign bus.any_pressed = any_q;
    assign bus.press_count = count_q;
endmodule

// File: tb/tb_button_input_conditioner.sv
// Randomised and directed bench for button_input_conditioner against a run-length debounce model.
module tb_button_input_conditioner;
    localparam int D = 8;
    localparam int W = 4;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    button_input_conditioner_if #(.WIDTH(W)) bus_if ();

    button_input_conditioner #(.DEBOUNCE_CYCLES(D), .WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    int checks = 0;
    int passes = 0;

    // model: a level flips once D consecutive synchronised samples disagree with it
    logic [W-1:0] m_level, m_pressed, raw_h1, raw_h2;
    logic [7:0]   m_count;
    int           run [W];
    logic         sel_m1, sel_m2, sw_prev;
    int           n_edges;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_level = '0; m_pressed = '0; raw_h1 = '0; raw_h2 = '0; m_count = '0;
        sel_m1 = 1'b0; sel_m2 = 1'b0; sw_prev = 1'b0; n_edges = 0;
        for (int i = 0; i < W; i++) run[i] = 0;
    endtask

    task automatic model_edge();
        logic [W-1:0] raw, s, ev;
        logic sw, blind;
        raw   = bus_if.src_sel ? bus_if.btn_a : bus_if.btn_b;
        sw    = (n_edges >= 2) && (sel_m1 != sel_m2);
        blind = sw || sw_prev;
        s     = raw_h2;
        ev    = '0;
        for (int i = 0; i < W; i++) begin
            if (blind) run[i] = 0;
            else if (s[i] != m_level[i]) begin
                run[i]++;
                if (run[i] >= D) begin
                    m_level[i] = s[i];
                    run[i] = 0;
                    if (s[i]) ev[i] = 1'b1;
                end
            end else run[i] = 0;
        end
        m_pressed = (bus_if.rd_strobe ? '0 : m_pressed) | ev;
        m_count   = m_count + 8'($countones(ev));
        raw_h2 = raw_h1; raw_h1 = raw;
        sel_m2 = sel_m1; sel_m1 = bus_if.src_sel;
        sw_prev = sw;
        n_edges++;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clock);
            model_edge();
            @(negedge clock);
            check("level",       32'(bus_if.level),       32'(m_level));
            check("pressed",     32'(bus_if.pressed),     32'(m_pressed));
            check("any_pressed", 32'(bus_if.any_pressed), 32'(|m_pressed));
            check("press_count", 32'(bus_if.press_count), 32'(m_count));
        end
    endtask

    task automatic read_pulse();
        bus_if.rd_strobe = 1'b1;
        ticks(1);
        bus_if.rd_strobe = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_level"},   32'(bus_if.level),       32'h0);
        check({tag, "_pressed"}, 32'(bus_if.pressed),     32'h0);
        check({tag, "_any"},     32'(bus_if.any_pressed), 32'h0);
        check({tag, "_count"},   32'(bus_if.press_count), 32'h0);
    endtask

    // async reset pulse placed between clock edges
    task automatic async_reset(input string tag);
        #2 reset = 1'b1;
        #1 check_all_zero(tag);
        model_reset();
        #1 reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus_if.src_sel = 1'b1; bus_if.btn_a = '0; bus_if.btn_b = '0; bus_if.rd_strobe = 1'b0;
        model_reset();
        #3 check_all_zero("reset");
        #9 reset = 1'b0;
        ticks(3);

        // clean press: level rises on the 10th edge after the input change
        bus_if.btn_a = 4'b0001;
        ticks(9);
        check("t1_level_early", 32'(bus_if.level), 32'h0);
        ticks(1);
        check("t1_level",   32'(bus_if.level),       32'h1);
        check("t1_pressed", 32'(bus_if.pressed),     32'h1);
        check("t1_any",     32'(bus_if.any_pressed), 32'h1);
        check("t1_count",   32'(bus_if.press_count), 32'h1);
        ticks(10);
        bus_if.btn_a = 4'b0000;
        ticks(12);
        read_pulse();
        check("t1_cleared", 32'(bus_if.pressed), 32'h0);

        // bounce on channel 1
        for (int j = 0; j < 10; j++) begin
            bus_if.btn_a = (j % 2 == 0) ? 4'b0010 : 4'b0000;
            ticks(3);
        end
        check("bounce_count_hold", 32'(bus_if.press_count), 32'h1);
        bus_if.btn_a = 4'b0010;
        ticks(12);
        check("bounce_pressed", 32'(bus_if.pressed),     32'h2);
        check("bounce_count",   32'(bus_if.press_count), 32'h2);

        // read-clear race
        bus_if.btn_a = 4'b0000;
        ticks(12);
        read_pulse();
        bus_if.btn_a = 4'b0001;
        ticks(10);
        check("race_pre", 32'(bus_if.pressed), 32'h1);
        bus_if.btn_a = 4'b0101;
        ticks(9);
        bus_if.rd_strobe = 1'b1;
        ticks(1);
        bus_if.rd_strobe = 1'b0;
        check("race_pressed", 32'(bus_if.pressed),     32'h4);
        check("race_count",   32'(bus_if.press_count), 32'h4);

        // source switch: blind window adds one edge to the debounce
        bus_if.btn_a = 4'b0000;
        ticks(12);
        read_pulse();
        bus_if.btn_b = 4'b1000;
        ticks(5);
        check("sw_pre_level", 32'(bus_if.level), 32'h0);
        bus_if.src_sel = 1'b0;
        ticks(10);
        check("sw_level_early",   32'(bus_if.level),   32'h0);
        check("sw_pressed_early", 32'(bus_if.pressed), 32'h0);
        ticks(1);
        check("sw_level",   32'(bus_if.level),       32'h8);
        check("sw_pressed", 32'(bus_if.pressed),     32'h8);
        check("sw_count",   32'(bus_if.press_count), 32'h5);

        // press_count wrap
        bus_if.src_sel = 1'b1; bus_if.btn_b = '0;
        async_reset("wrap_rst");
        for (int j = 0; j < 256; j++) begin
            bus_if.btn_a = 4'b0001;
            ticks(10);
            bus_if.btn_a = 4'b0000;
            ticks(10);
        end
        check("wrap_count", 32'(bus_if.press_count), 32'h0);
        bus_if.btn_a = 4'b1111;
        ticks(10);
        check("multi_count",   32'(bus_if.press_count), 32'h4);
        check("multi_pressed", 32'(bus_if.pressed),     32'hf);

        // reset mid-debounce with the input still held
        bus_if.btn_a = 4'b0000;
        ticks(12);
        bus_if.btn_a = 4'b0001;
        ticks(5);
        async_reset("mid_rst");
        ticks(9);
        check("rst_level_early", 32'(bus_if.level), 32'h0);
        ticks(1);
        check("rst_level", 32'(bus_if.level),       32'h1);
        check("rst_count", 32'(bus_if.press_count), 32'h1);

        // randomised run
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(11) == 0) bus_if.btn_a = 4'($urandom);
            if ($urandom_range(11) == 0) bus_if.btn_b = 4'($urandom);
            if ($urandom_range(199) == 0) bus_if.src_sel = ~bus_if.src_sel;
            bus_if.rd_strobe = ($urandom_range(4) == 0);
            ticks(1);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
